// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared constants and FSM encoding for the UART TX byte buffer
package uart_tx_fifo_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    S_DRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_REQ   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - generic DEPTH x byte synchronous FIFO with registered flags
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd,
  input  logic              clr_ovf,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              wr_ok, rd_ok;

  // Acceptance uses the pre-edge flags, so a write while full is dropped even if a pop coincides.
  always_comb begin
    wr_ok    = wr && !full_q;
    rd_ok    = rd && !empty_q;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
    ovf_d   = (ovf_q && !clr_ovf) || (wr && full_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter's write/busy handshake
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [BYTE_W-1:0] i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count,
  output logic              o_overflow,
  input  logic              i_clr_ovf,
  output logic              o_tx_write,
  output logic [BYTE_W-1:0] o_tx_data,
  input  logic              i_tx_busy
);

  logic [BYTE_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              pop;

  tx_state_e         state_q, state_d;
  logic              tx_write_q, tx_write_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .wr       (i_wr),
    .wr_data  (i_wr_data),
    .rd       (pop),
    .clr_ovf  (i_clr_ovf),
    .rd_data  (fifo_rd_data),
    .full     (o_full),
    .empty    (fifo_empty),
    .count    (o_count),
    .overflow (o_overflow)
  );

  // The byte stays at the FIFO head until the transmitter shows busy; only then is it popped.
  always_comb begin
    state_d    = state_q;
    tx_write_d = tx_write_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      S_DRAIN: begin
        tx_write_d = 1'b0;
        if (!i_tx_busy) state_d = S_IDLE;
      end
      S_IDLE: begin
        tx_write_d = 1'b0;
        if (!fifo_empty) begin
          tx_data_d  = fifo_rd_data;
          tx_write_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (i_tx_busy) begin
          pop        = 1'b1;
          tx_write_d = 1'b0;
          state_d    = S_DRAIN;
        end
      end
      default: begin
        tx_write_d = 1'b0;
        state_d    = S_DRAIN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_DRAIN;
      tx_write_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_empty    = fifo_empty;
  assign o_tx_write = tx_write_q;
  assign o_tx_data  = tx_data_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer directly upstream of the UART transmitter.
- Accepts bursts of bytes from a producer, such as a message/string sequencer, at full i_clk rate.
- Feeds the bytes one at a time to the transmitter's write/busy interface, so the producer never stalls on baud timing.
- Holds each byte and its write strobe until the transmitter, which samples only on its baud tick, has visibly taken it.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- AW, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- i_clk, input, 1: system clock; the only clock.
- i_rst_n, input, 1: reset, synchronous, active-low.
- i_wr, input, 1: producer write strobe; one byte per cycle while high.
- i_wr_data, input, 8: producer byte.
- o_full, output, 1: FIFO full; a write this cycle is rejected.
- o_empty, output, 1: FIFO holds no bytes.
- o_count, output, AW+1: current occupancy, 0..DEPTH.
- o_overflow, output, 1: sticky; a write was attempted while full.
- i_clr_ovf, input, 1: clears o_overflow.
- o_tx_write, output, 1: byte-available strobe to the transmitter.
- o_tx_data, output, 8: byte to the transmitter; valid while o_tx_write=1.
- i_tx_busy, input, 1: transmitter busy, level. 1 from byte capture until the stop bit completes.

Behaviour:
- Reset applies on any i_clk edge with i_rst_n=0:
  - pointers and count go to 0; o_empty=1, o_full=0, o_overflow=0;
  - o_tx_write=0, o_tx_data=8'h00;
  - FSM goes to S_DRAIN.
- Write side:
  - i_wr=1 and o_full=0: store the byte at wr_ptr, increment the pointer (wrap modulo DEPTH); occupancy +1.
  - i_wr=1 and o_full=1: byte dropped, o_overflow<=1. This holds even if a pop occurs in the same cycle, because full is evaluated on the pre-edge state.
- Flags:
  - o_full = (count==DEPTH); o_empty = (count==0).
  - All flags are registered and update on the cycle after the event.
- Pop and write in the same cycle (FIFO not full): count unchanged, both pointers advance.
- o_overflow:
  - cleared by i_clr_ovf=1;
  - if an overflowing write coincides with i_clr_ovf, o_overflow ends up 1.
- FSM (all transitions on i_clk):
  - S_DRAIN: o_tx_write=0. Waits for i_tx_busy=0 (the transmitter may still be mid-byte after a reset or a previous byte), then goes to S_IDLE.
  - S_IDLE: o_tx_write=0. If the FIFO is not empty, register o_tx_data<=mem[rd_ptr] and go to S_REQ.
  - S_REQ: o_tx_write=1 and o_tx_data held stable. On the first cycle with i_tx_busy=1, pop the FIFO (rd_ptr+1, wrapping), drive o_tx_write<=0, and go to S_DRAIN.
- Latency, first byte:
  - write at cycle N; o_empty falls at N+1; S_IDLE sees non-empty and loads o_tx_data at N+1; o_tx_write=1 from N+2.
  - The pop waits an unbounded time for busy, governed by the baud tick.
- Throughput: one byte per transmitter frame. Once busy falls, the next o_tx_write rises after a fixed 2-cycle gap (S_DRAIN→S_IDLE→S_REQ).
- S_REQ never times out. A transmitter that never asserts busy stalls the FIFO, and producer writes continue until full.
- i_tx_busy=1 already on entry to S_REQ (not expected after S_DRAIN): pop on the next edge as normal.
- Reset mid-frame: FIFO contents are discarded; o_tx_write drops at the reset edge; no new byte is issued until i_tx_busy=0.

Decomposition:
- Shared uart package holds:
  - the byte-width constant (8);
  - the FSM state encoding as a typedef (S_DRAIN, S_IDLE, S_REQ);
  - default DEPTH.
- One natural sub-module: sync_fifo, a generic DEPTH×8 synchronous FIFO with wr/rd/full/empty/count/overflow. uart_tx_fifo wraps it and adds the FSM.

Test Plan:
- Reset with i_tx_busy=1 held 20 cycles, then 0, with FIFO pre-written with 8'h48 → o_tx_write stays 0 until 2 cycles after busy falls; then o_tx_data=8'h48 and o_tx_write=1.
- Write "He" (8'h48, 8'h65) back-to-back, connected to the transmitter built with TESTING defined → the transmitter captures 8'h48 then 8'h65 in order; o_count goes 2→1→0; line bits are 1,0,00010010,1,… LSB-first.
- Write 16 bytes with busy stuck at 1 → o_full=1 at count 16; a 17th write sets o_overflow=1; count stays 16; i_clr_ovf clears the flag.
- Write 16 bytes, then release busy → all 16 bytes delivered in order; pointer wraps; a write on the same cycle as the first pop is rejected because the FIFO was full.
- Count 5, busy toggling: write and pop in the same cycle → o_count stays 5; the byte order of the later read-out is preserved.
- Assert i_rst_n=0 while in S_REQ with count 3 → next edge: o_tx_write=0, o_count=0, o_empty=1; no byte is issued after reset until new writes occur.
